// File: rtl/reset_sequencer_if.sv
// Reset sequencer request/status bundle: button and software request in, staged domain resets and status out.
// The sequencer drives through the slave modport; the surrounding logic or bench uses master.
interface reset_sequencer_if #(
   parameter int N_DOMAINS = 4
) ();
   logic                 button_n;
   logic                 sw_req;
   logic                 sw_ack;
   logic [N_DOMAINS-1:0] domain_reset_n;
   logic                 ready;
   logic [1:0]           cause;

   modport master (
      output button_n, sw_req,
      input  sw_ack, domain_reset_n, ready, cause
   );

   modport slave (
      input  button_n, sw_req,
      output sw_ack, domain_reset_n, ready, cause
   );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset release: domains come out of reset one per STAGE_CYCLES after a one-stage hold; all outputs registered.
// Optional button debouncer is built only when RESET_SEQ_DEBOUNCE_EN is defined.
module reset_sequencer #(
   parameter int N_DOMAINS       = 4,
   parameter int STAGE_CYCLES    = 16,
   parameter int DEBOUNCE_CYCLES = 1024
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   reset_sequencer_if.slave   bus
);
   localparam int CNT_W = $clog2(STAGE_CYCLES);
   localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DOMAINS - 1);

   typedef enum logic [1:0] {S_HOLD, S_RELEASE, S_RUN} state_t;

   logic [1:0] rst_sync_q;
   logic       rst_int_n;
   logic [1:0] btn_sync_q;
   logic       btn_n;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) rst_sync_q <= 2'b00;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_int_n = rst_sync_q[1];

   always_ff @(posedge clk_i or negedge rst_int_n) begin
      if (!rst_int_n) btn_sync_q <= 2'b11;
      else            btn_sync_q <= {btn_sync_q[0], bus.button_n};
   end

`ifdef RESET_SEQ_DEBOUNCE_EN
   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   logic [DB_W-1:0] db_cnt_q;
   logic            btn_n_q;

   // Counts consecutive cycles the synchronized level disagrees with the debounced one.
   always_ff @(posedge clk_i or negedge rst_int_n) begin
      if (!rst_int_n) begin
         db_cnt_q <= '0;
         btn_n_q  <= 1'b1;
      end else if (btn_sync_q[1] == btn_n_q) begin
         db_cnt_q <= '0;
      end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
         db_cnt_q <= '0;
         btn_n_q  <= btn_sync_q[1];
      end else begin
         db_cnt_q <= db_cnt_q + DB_W'(1);
      end
   end
   assign btn_n = btn_n_q;
`else
   assign btn_n = btn_sync_q[1];
`endif

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [N_DOMAINS-1:0] dom_q, dom_d;
   logic                 ready_q, ready_d;
   logic [1:0]           cause_q, cause_d;
   logic                 sw_ack_q, sw_ack_d;

   always_ff @(posedge clk_i or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q  <= S_HOLD;
         cnt_q    <= '0;
         idx_q    <= '0;
         dom_q    <= '0;
         ready_q  <= 1'b0;
         cause_q  <= 2'b00;
         sw_ack_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         dom_q    <= dom_d;
         ready_q  <= ready_d;
         cause_q  <= cause_d;
         sw_ack_q <= sw_ack_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      dom_d    = dom_q;
      ready_d  = ready_q;
      cause_d  = cause_q;
      sw_ack_d = 1'b0;
      case (state_q)
         S_HOLD: begin
            dom_d   = '0;
            ready_d = 1'b0;
            if (!btn_n) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = S_RELEASE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RELEASE: begin
            if (!btn_n) begin
               state_d = S_HOLD;
               dom_d   = '0;
               ready_d = 1'b0;
               cause_d = 2'b01;
               cnt_d   = '0;
               idx_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d        = '0;
               dom_d[idx_q] = 1'b1;
               if (idx_q == IDX_LAST) begin
                  ready_d = 1'b1;
                  idx_d   = '0;
                  state_d = S_RUN;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RUN: begin
            // Button wins the cause code, but a concurrent software request is still acknowledged.
            if (!btn_n || bus.sw_req) begin
               state_d  = S_HOLD;
               dom_d    = '0;
               ready_d  = 1'b0;
               cnt_d    = '0;
               idx_d    = '0;
               cause_d  = (!btn_n) ? 2'b01 : 2'b10;
               sw_ack_d = bus.sw_req;
            end
         end
         default: state_d = S_HOLD;
      endcase
   end

   assign bus.domain_reset_n = dom_q;
   assign bus.ready          = ready_q;
   assign bus.cause          = cause_q;
   assign bus.sw_ack         = sw_ack_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus pushes predicted output changes and ack pulses with their cycle stamps.
// A negedge monitor pops and compares whenever the DUT outputs change or SW_ACK pulses.
module tb_reset_sequencer;
   localparam int ND = 4;
   localparam int SC = 16;
`ifdef RESET_SEQ_DEBOUNCE_EN
   localparam int DB = 8;
`else
   localparam int DB = 0;
`endif
   localparam int BL = DB + 5;

   typedef struct {
      int         cyc;
      logic [3:0] dom;
      logic       rdy;
      logic [1:0] cause;
   } ev_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   vectors;
   int   miscompares;
   ev_t  exp_q[$];
   int   ack_q[$];
   logic [3:0] last_dom;
   logic       last_rdy;
   logic [1:0] last_cause;

   reset_sequencer_if #(.N_DOMAINS(ND)) bus ();

   reset_sequencer #(
      .N_DOMAINS(ND), .STAGE_CYCLES(SC), .DEBOUNCE_CYCLES(8)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic push_ev(input int c, input logic [3:0] d, input logic r, input logic [1:0] ca);
      ev_t e;
      e.cyc = c; e.dom = d; e.rdy = r; e.cause = ca;
      exp_q.push_back(e);
   endtask

   // Domain k released at base + (k+2)*SC, READY with the last one.
   task automatic push_seq(input int b, input int n, input logic [1:0] ca);
      for (int k = 0; k < n; k++) begin
         logic [4:0] t;
         t = 5'((1 << (k + 1)) - 1);
         push_ev(b + (k + 2) * SC, t[3:0], k == ND - 1, ca);
      end
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic sw_pulse(output int b);
      int c;
      c = cyc;
      bus.sw_req = 1'b1;
      push_ev(c + 1, 4'b0000, 1'b0, 2'b10);
      ack_q.push_back(c + 1);
      @(negedge clk);
      bus.sw_req = 1'b0;
      b = c + 1;
   endtask

   always @(negedge clk) begin
      if ({bus.domain_reset_n, bus.ready, bus.cause} !== {last_dom, last_rdy, last_cause}) begin
         chk("evt_pending", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            chk("evt_cyc", 32'(cyc), 32'(e.cyc));
            chk("dom", 32'(bus.domain_reset_n), 32'(e.dom));
            chk("ready", 32'(bus.ready), 32'(e.rdy));
            chk("cause", 32'(bus.cause), 32'(e.cause));
         end
         last_dom   = bus.domain_reset_n;
         last_rdy   = bus.ready;
         last_cause = bus.cause;
      end
      if (bus.sw_ack !== 1'b0) begin
         chk("ack_pending", 32'(ack_q.size() > 0), 32'd1);
         if (ack_q.size() > 0) chk("ack_cyc", 32'(cyc), 32'(ack_q.pop_front()));
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int b;
      vectors     = 0;
      miscompares = 0;
      last_dom    = 4'b0000;
      last_rdy    = 1'b0;
      last_cause  = 2'b00;
      rst_n       = 1'b0;
      bus.button_n = 1'b1;
      bus.sw_req   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_dom", 32'(bus.domain_reset_n), 32'd0);
      chk("rst_ready", 32'(bus.ready), 32'd0);
      chk("rst_cause", 32'(bus.cause), 32'd0);
      chk("rst_ack", 32'(bus.sw_ack), 32'd0);

      // POR release: two sync edges, then the staged release.
      c = cyc;
      rst_n = 1'b1;
      push_seq(c + 2, ND, 2'b00);
      wait_cyc(c + 2 + 84);

      // Single-cycle software request in RUN.
      sw_pulse(b);
      push_seq(b, ND, 2'b10);
      wait_cyc(b + 84);

      // Software request held while domain 1 is pending: ignored.
      sw_pulse(b);
      push_seq(b, ND, 2'b10);
      wait_cyc(b + 2 * SC + 3);
      bus.sw_req = 1'b1;
      repeat (10) @(negedge clk);
      bus.sw_req = 1'b0;
      wait_cyc(b + 84);

      // Held software request retriggers on the first RUN cycle.
      c = cyc;
      bus.sw_req = 1'b1;
      push_ev(c + 1, 4'b0000, 1'b0, 2'b10);
      ack_q.push_back(c + 1);
      b = c + 1;
      push_seq(b, ND, 2'b10);
      push_ev(b + 81, 4'b0000, 1'b0, 2'b10);
      ack_q.push_back(b + 81);
      push_seq(b + 81, ND, 2'b10);
      wait_cyc(b + 81);
      bus.sw_req = 1'b0;
      wait_cyc(b + 81 + 84);

      // Button abort after domain 1 released.
      sw_pulse(b);
      push_seq(b, 2, 2'b10);
      wait_cyc(b + 3 * SC + 3);
      c = cyc;
      bus.button_n = 1'b0;
      push_ev(c + 3 + DB, 4'b0000, 1'b0, 2'b01);
      wait_cyc(c + BL);
      bus.button_n = 1'b1;
      b = c + BL + 2 + DB;
      push_seq(b, ND, 2'b01);
      wait_cyc(b + 84);

      // Button and software request land on the same RUN edge.
      c = cyc;
      bus.button_n = 1'b0;
      wait_cyc(c + 2 + DB);
      bus.sw_req = 1'b1;
      push_ev(c + 3 + DB, 4'b0000, 1'b0, 2'b01);
      ack_q.push_back(c + 3 + DB);
      @(negedge clk);
      bus.sw_req = 1'b0;
      wait_cyc(c + BL);
      bus.button_n = 1'b1;
      b = c + BL + 2 + DB;
      push_seq(b, ND, 2'b01);
      wait_cyc(b + 84);

`ifdef RESET_SEQ_DEBOUNCE_EN
      // A glitch one cycle short of the window is swallowed; the full window resets.
      sw_pulse(b);
      push_seq(b, ND, 2'b10);
      wait_cyc(b + 84);
      c = cyc;
      bus.button_n = 1'b0;
      wait_cyc(c + 7);
      bus.button_n = 1'b1;
      wait_cyc(c + 30);
      c = cyc;
      bus.button_n = 1'b0;
      push_ev(c + 3 + DB, 4'b0000, 1'b0, 2'b01);
      wait_cyc(c + 8);
      bus.button_n = 1'b1;
      b = c + 8 + 2 + DB;
      push_seq(b, ND, 2'b01);
      wait_cyc(b + 84);
`endif

      // RESET_N mid-RELEASE clears outputs without a clock edge.
      sw_pulse(b);
      push_seq(b, 2, 2'b10);
      wait_cyc(b + 3 * SC + 3);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      push_ev(cyc, 4'b0000, 1'b0, 2'b00);
      #1;
      chk("async_dom", 32'(bus.domain_reset_n), 32'd0);
      chk("async_ready", 32'(bus.ready), 32'd0);
      chk("async_cause", 32'(bus.cause), 32'd0);
      repeat (3) @(negedge clk);
      c = cyc;
      rst_n = 1'b1;
      push_seq(c + 2, ND, 2'b00);
      wait_cyc(c + 2 + 84);

      repeat (5) @(negedge clk);
      chk("evt_left", 32'(exp_q.size()), 32'd0);
      chk("ack_left", 32'(ack_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
